seq_shift_add_mult: RTL and testbench
=====================================

// Module: seq_shift_add_mult
//
// PURPOSE
//   Sequential unsigned shift-and-add multiplier; one partial product is
//   processed per clock. All state lives in registers built from the team's
//   master-slave D flip-flop cell. It consumes two WIDTH-bit operands on a
//   START pulse and returns a 2*WIDTH-bit product with a one-cycle DONE strobe.
//   It is the register-level datapath stage that sits directly downstream of
//   the flip-flop cell in the multiplier suite.
//
// PARAMETERS
//   WIDTH   8   Operand width in bits; must be >= 2. Product is 2*WIDTH bits.
//
// PORTS
//   CLK     in   1         Clock. All state updates on the FALLING edge.
//   RST_N   in   1         Asynchronous, active-low reset.
//   START   in   1         Load request; sampled only in IDLE or DONE.
//   A       in   WIDTH     Multiplicand, captured when START is accepted.
//   B       in   WIDTH     Multiplier, captured when START is accepted.
//   BUSY    out  1         High while the iteration is running.
//   DONE    out  1         One-cycle strobe; P is valid from this cycle on.
//   P       out  2*WIDTH   Product; holds until the next accepted START.
//
// BEHAVIOUR
//   - Reset (RST_N=0, asynchronous, any time including mid-run):
//     state=IDLE, BUSY=0, DONE=0, P=0, ACC=0, MQ=0, MCAND=0, CNT=0.
//   - FSM states: IDLE, RUN, FIN. Outputs are registered (Moore).
//     IDLE: START=1 -> MCAND<=A, MQ<=B, ACC<=0, C<=0, CNT<=0; go to RUN.
//     RUN : each edge {C,ACC} <= ACC + (MQ[0] ? MCAND : 0);
//           then {C,ACC,MQ} is shifted right by 1; CNT<=CNT+1.
//           When CNT==WIDTH-1 on this edge, go to FIN. START is ignored.
//     FIN : P<={ACC,MQ}, DONE=1 for exactly one cycle. START=1 here is
//           accepted as in IDLE (go to RUN); otherwise go to IDLE.
//   - BUSY=1 exactly while the state is RUN (WIDTH cycles).
//   - Latency: START sampled at falling edge k -> DONE=1 after edge k+WIDTH+1.
//     Back-to-back throughput is one product per WIDTH+1 cycles.
//   - Arithmetic: unsigned. ACC is WIDTH bits plus carry C; no overflow is
//     possible, because the product fits in 2*WIDTH bits.
//   - CNT width is $clog2(WIDTH). It never wraps, because it is reloaded on START.
//   - A and B may change freely after START is accepted; only the captured
//     copies are used.
//   - P is not updated during RUN; it keeps the previous product.
//
// STRUCTURE
//   - Shared package mult_pkg: state encoding localparams
//     (ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIN=2'd2) and default WIDTH,
//     for reuse by the other multiplier variants.
//   - One sub-module: dff_reg_n (N-bit, falling-edge register with async
//     active-low clear and load enable). It is instantiated for ACC, MQ,
//     MCAND, CNT and P. The adder and the FSM next-state logic stay inline.
//
// TESTING  (WIDTH=8; drive inputs on the rising edge, check after the falling edge)
//   1. Reset, then START with A=13, B=11 -> BUSY high 8 cycles, then DONE pulses
//      once, P=143, and P is still 143 five cycles later.
//   2. A=255, B=255 -> P=65025 (0xFE01); the carry path into ACC is exercised.
//   3. A=0, B=200 and A=200, B=0 -> P=0; DONE timing identical to scenario 1.
//   4. START re-asserted every cycle during RUN, with A, B changed each time
//      -> ignored; P = product of the first A,B. START held high in FIN
//      -> new run starts immediately.
//   5. RST_N pulled low on the 4th RUN cycle -> BUSY, DONE and P go to 0
//      immediately (no clock edge). After release, START A=7, B=9 -> P=63.
//   6. Randomised 200 operand pairs vs a reference A*B -> zero mismatches.
//      DONE is asserted exactly WIDTH+1 cycles after each accepted START.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mult_pkg
//  Description : Shared definitions for the multiplier suite: state
//                encoding of the sequential multiplier control FSM and the
//                default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_FIN  = ST_FIN
  } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/dff_reg_n.sv
`default_nettype none
// ============================================================================
//  Module      : dff_reg_n
//  Description : N-bit register, updates on the falling clock edge, with an
//                asynchronous active-low clear and a load enable.
//  Ports       : clk   in  1   clock (falling edge active)
//                rst_n in  1   asynchronous clear, active low
//                en    in  1   load enable
//                d     in  N   next value
//                q     out N   registered value
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_reg_n #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : dff_reg_n
`default_nettype wire

// File: rtl/seq_shift_add_mult.sv
`default_nettype none
// ============================================================================
//  Module      : seq_shift_add_mult
//  Description : Sequential unsigned shift-and-add multiplier. One partial
//                product per (falling) clock edge; WIDTH+1 cycles per product.
//  Ports       : CLK   in  1        clock, state changes on falling edge
//                RST_N in  1        asynchronous reset, active low
//                START in  1        load request (accepted in IDLE / FIN)
//                A     in  WIDTH    multiplicand
//                B     in  WIDTH    multiplier
//                BUSY  out 1        high while iterating
//                DONE  out 1        one-cycle strobe, P valid from here on
//                P     out 2*WIDTH  product, held until the next product
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [2*WIDTH-1:0]   P
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t               state_d, state_q;
  logic [1:0]           state_raw_q;
  logic                 busy_d, busy_q;
  logic                 done_d, done_q;
  logic [WIDTH-1:0]     acc_d, acc_q;
  logic [WIDTH-1:0]     mq_d, mq_q;
  logic [WIDTH-1:0]     mcand_d, mcand_q;
  logic [CW-1:0]        cnt_d, cnt_q;
  logic [2*WIDTH-1:0]   p_d, p_q;
  logic                 p_en;
  logic                 accept;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;

  assign state_q = state_t'(state_raw_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;

    accept = START && ((state_q == S_IDLE) || (state_q == S_FIN));
    addend = mq_q[0] ? mcand_q : {WIDTH{1'b0}};
    // sum[WIDTH] is the carry C; it is consumed by the shift in the same
    // edge, so it never needs its own register.
    sum    = {1'b0, acc_q} + {1'b0, addend};

    case (state_q)
      S_IDLE:  if (START) state_d = S_RUN;
      S_RUN:   if (cnt_q == CNT_LAST) state_d = S_FIN;
      S_FIN:   state_d = START ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      mcand_d = A;
      mq_d    = B;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      // Add-then-shift of {C,ACC,MQ}: the retired multiplier bit falls out
      // of MQ while the low sum bit enters at its top.
      acc_d = sum[WIDTH:1];
      mq_d  = {sum[0], mq_q[WIDTH-1:1]};
      cnt_d = cnt_q + CW'(1);
    end

    busy_d = (state_d == S_RUN);
    // DONE and P follow the FIN cycle, giving WIDTH+1 edges of latency.
    done_d = (state_q == S_FIN);
    p_en   = (state_q == S_FIN);
    p_d    = {acc_q, mq_q};
  end

  dff_reg_n #(.N(2)) u_state (
    .clk(CLK), .rst_n(RST_N), .en(1'b1), .d(state_d), .q(state_raw_q)
  );

  dff_reg_n #(.N(1)) u_busy (
    .clk(CLK), .rst_n(RST_N), .en(1'b1), .d(busy_d), .q(busy_q)
  );

  dff_reg_n #(.N(1)) u_done (
    .clk(CLK), .rst_n(RST_N), .en(1'b1), .d(done_d), .q(done_q)
  );

  dff_reg_n #(.N(WIDTH)) u_acc (
    .clk(CLK), .rst_n(RST_N), .en(1'b1), .d(acc_d), .q(acc_q)
  );

  dff_reg_n #(.N(WIDTH)) u_mq (
    .clk(CLK), .rst_n(RST_N), .en(1'b1), .d(mq_d), .q(mq_q)
  );

  dff_reg_n #(.N(WIDTH)) u_mcand (
    .clk(CLK), .rst_n(RST_N), .en(1'b1), .d(mcand_d), .q(mcand_q)
  );

  dff_reg_n #(.N(CW)) u_cnt (
    .clk(CLK), .rst_n(RST_N), .en(1'b1), .d(cnt_d), .q(cnt_q)
  );

  dff_reg_n #(.N(2*WIDTH)) u_p (
    .clk(CLK), .rst_n(RST_N), .en(p_en), .d(p_d), .q(p_q)
  );

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign P    = p_q;

endmodule : seq_shift_add_mult
`default_nettype wire

// File: tb/tb_seq_shift_add_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_shift_add_mult
//  Description : Self-checking bench for seq_shift_add_mult (WIDTH=8).
//                Inputs change on the rising edge, outputs are sampled 1 ns
//                after the falling (active) edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shift_add_mult;

  localparam int W   = 8;
  localparam int LAT = W + 1;

  logic          CLK;
  logic          RST_N;
  logic          START;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          BUSY;
  logic          DONE;
  logic [2*W-1:0] P;

  int pass_cnt  = 0;
  int total_cnt = 0;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .P(P)
  );

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  // Issue one START and wait (bounded) for DONE. lat counts falling edges
  // from the accepting edge to the DONE sample; busy_n counts BUSY samples.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit scramble, output int lat, output int busy_n);
    @(posedge CLK); START = 1'b1; A = a; B = b;
    @(negedge CLK); #1;
    lat    = 0;
    busy_n = BUSY ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      START = 1'b0;
      if (scramble) begin A = 8'($urandom); B = 8'($urandom); end
      @(negedge CLK); #1;
      lat++;
      if (BUSY) busy_n++;
      if (DONE) break;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b1; START = 1'b0; A = '0; B = '0;
    #1 RST_N = 1'b0;
    #1;
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else pass_cnt++;
    total_cnt++; if (DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", DONE); else pass_cnt++;
    total_cnt++; if (P !== 16'd0) $display("FAIL reset_p: got %0d want 0", P); else pass_cnt++;
    @(posedge CLK); RST_N = 1'b1;
  endtask

  task automatic test_basic();
    int lat, busy_n;
    run_op(8'd13, 8'd11, 1'b0, lat, busy_n);
    total_cnt++; if (lat !== LAT) $display("FAIL basic_latency: got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (busy_n !== W) $display("FAIL basic_busy_cycles: got %0d want %0d", busy_n, W); else pass_cnt++;
    total_cnt++; if (P !== 16'd143) $display("FAIL basic_product: got %0d want 143", P); else pass_cnt++;
    @(negedge CLK); #1;
    total_cnt++; if (DONE !== 1'b0) $display("FAIL basic_done_strobe: got %b want 0", DONE); else pass_cnt++;
    repeat (4) @(negedge CLK);
    #1;
    total_cnt++; if (P !== 16'd143) $display("FAIL basic_hold: got %0d want 143", P); else pass_cnt++;
  endtask

  task automatic test_max();
    int lat, busy_n;
    run_op(8'd255, 8'd255, 1'b1, lat, busy_n);
    total_cnt++; if (lat !== LAT) $display("FAIL max_latency: got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (P !== 16'hFE01) $display("FAIL max_product: got %0h want fe01", P); else pass_cnt++;
  endtask

  task automatic test_zero();
    int lat, busy_n;
    run_op(8'd0, 8'd200, 1'b0, lat, busy_n);
    total_cnt++; if (lat !== LAT) $display("FAIL zero_a_latency: got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (P !== 16'd0) $display("FAIL zero_a_product: got %0d want 0", P); else pass_cnt++;
    run_op(8'd200, 8'd0, 1'b0, lat, busy_n);
    total_cnt++; if (lat !== LAT) $display("FAIL zero_b_latency: got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (P !== 16'd0) $display("FAIL zero_b_product: got %0d want 0", P); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, lat2;
    logic [W-1:0] a0, b0, la, lb;
    a0 = 8'd37; b0 = 8'd201; la = '0; lb = '0;
    @(posedge CLK); START = 1'b1; A = a0; B = b0;
    @(negedge CLK); #1;
    lat = 0;
    // START stays high the whole run with fresh operands each cycle.
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      A = 8'($urandom_range(1, 255)); B = 8'($urandom_range(1, 255));
      la = A; lb = B;
      @(negedge CLK); #1;
      lat++;
      if (DONE) break;
    end
    total_cnt++; if (lat !== LAT) $display("FAIL b2b_latency1: got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (P !== 16'(int'(a0) * int'(b0))) $display("FAIL b2b_product1: got %0d want %0d", P, int'(a0) * int'(b0)); else pass_cnt++;
    total_cnt++; if (BUSY !== 1'b1) $display("FAIL b2b_restart_busy: got %b want 1", BUSY); else pass_cnt++;
    lat2 = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); START = 1'b0;
      @(negedge CLK); #1;
      lat2++;
      if (DONE) break;
    end
    total_cnt++; if (lat2 !== LAT) $display("FAIL b2b_latency2: got %0d want %0d", lat2, LAT); else pass_cnt++;
    total_cnt++; if (P !== 16'(int'(la) * int'(lb))) $display("FAIL b2b_product2: got %0d want %0d", P, int'(la) * int'(lb)); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int lat, busy_n;
    @(posedge CLK); START = 1'b1; A = 8'd100; B = 8'd3;
    @(negedge CLK);
    @(posedge CLK); START = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    total_cnt++; if (BUSY !== 1'b1) $display("FAIL arst_busy_before: got %b want 1", BUSY); else pass_cnt++;
    #1 RST_N = 1'b0;
    #1;
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL arst_busy: got %b want 0", BUSY); else pass_cnt++;
    total_cnt++; if (DONE !== 1'b0) $display("FAIL arst_done: got %b want 0", DONE); else pass_cnt++;
    total_cnt++; if (P !== 16'd0) $display("FAIL arst_p: got %0d want 0", P); else pass_cnt++;
    @(posedge CLK); RST_N = 1'b1;
    run_op(8'd7, 8'd9, 1'b0, lat, busy_n);
    total_cnt++; if (lat !== LAT) $display("FAIL arst_latency: got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (P !== 16'd63) $display("FAIL arst_product: got %0d want 63", P); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, busy_n, expv;
    logic [W-1:0] a, b;
    for (int n = 0; n < 200; n++) begin
      a = 8'($urandom); b = 8'($urandom);
      expv = int'(a) * int'(b);
      run_op(a, b, 1'b1, lat, busy_n);
      total_cnt++; if (lat !== LAT) $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, LAT); else pass_cnt++;
      total_cnt++; if (P !== 16'(expv)) $display("FAIL rand_product[%0d] %0d*%0d: got %0d want %0d", n, a, b, P, expv); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_seq_shift_add_mult
`default_nettype wire
